// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: program-ROM fetch sequencer.
// Owns the PC and drives the ROM address/enable. Each fetched word is captured
// into an instruction register and offered to the decoder over valid/ready.
// Jumps flush the pending word. Halt either stops at once or drains the
// pending word first.
module rom_fetch_unit #(
  parameter int                PCW      = 8,
  parameter int                IW       = 13,
  parameter logic [PCW-1:0]    RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_run,
  input  logic            i_halt,
  input  logic            i_jmp_en,
  input  logic [PCW-1:0]  i_jmp_addr,
  output logic [PCW-1:0]  o_rom_addr,
  output logic            o_rom_en,
  input  logic [IW-1:0]   i_rom_data,
  output logic [IW-1:0]   o_ir,
  output logic [PCW-1:0]  o_ir_pc,
  output logic            o_ir_valid,
  input  logic            i_ir_ready,
  output logic            o_busy,
  output logic            o_wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PCW-1:0]  r_pc;
  logic [IW-1:0]   r_ir;
  logic [PCW-1:0]  r_ir_pc;
  logic            r_ir_valid;
  logic            r_wrap;
  logic            w_ld;
  logic            w_clr_valid;

  // Load condition: fetch only in RUN when the IR slot is free or being
  // consumed this cycle, and no jump or halt claims the edge.
  assign w_ld = (r_state == S_RUN) & (~r_ir_valid | i_ir_ready) & ~i_jmp_en & ~i_halt;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and IR-invalidate request; jump outranks halt outranks run.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_run && !i_halt) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_jmp_en) begin
          // Flush; a simultaneous halt sees an empty IR and stops at once.
          w_clr_valid = 1'b1;
          if (i_halt) w_state_nxt = S_IDLE;
        end else if (i_halt) begin
          if (!r_ir_valid || i_ir_ready) begin
            w_clr_valid = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (i_jmp_en || i_ir_ready) begin
          w_clr_valid = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC, instruction register and wrap pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= w_ld && (r_pc == {PCW{1'b1}});
      if (i_jmp_en)  r_pc <= i_jmp_addr;
      else if (w_ld) r_pc <= r_pc + 1'b1;
      if (w_ld) begin
        r_ir       <= i_rom_data;
        r_ir_pc    <= r_pc;
        r_ir_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign o_rom_addr = r_pc;
  assign o_rom_en   = w_ld;
  assign o_ir       = r_ir;
  assign o_ir_pc    = r_ir_pc;
  assign o_ir_valid = r_ir_valid;
  assign o_busy     = (r_state != S_IDLE);
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed test-plan steps followed by random
// stimulus, every cycle compared against a behavioural model of the fetcher.
module tb_rom_fetch_unit;

  localparam int PCW = 8;
  localparam int IW  = 13;

  logic            clk;
  logic            rst_n;
  logic            run;
  logic            halt;
  logic            jmp_en;
  logic [PCW-1:0]  jmp_addr;
  logic [PCW-1:0]  rom_addr;
  logic            rom_en;
  logic [IW-1:0]   rom_data;
  logic [IW-1:0]   ir;
  logic [PCW-1:0]  ir_pc;
  logic            ir_valid;
  logic            ir_ready;
  logic            busy;
  logic            wrap;

  int n_assert = 0;
  int n_fail   = 0;

  rom_fetch_unit #(.PCW(PCW), .IW(IW), .RESET_PC('0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_run      (run),
    .i_halt     (halt),
    .i_jmp_en   (jmp_en),
    .i_jmp_addr (jmp_addr),
    .o_rom_addr (rom_addr),
    .o_rom_en   (rom_en),
    .i_rom_data (rom_data),
    .o_ir       (ir),
    .o_ir_pc    (ir_pc),
    .o_ir_valid (ir_valid),
    .i_ir_ready (ir_ready),
    .o_busy     (busy),
    .o_wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word = address, except address 1 holds 0x0F0.
  function automatic logic [IW-1:0] rom_word(input logic [PCW-1:0] a);
    return (a == 8'd1) ? 13'h0F0 : {5'b0, a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  // Behavioural model: mode 0=stopped, 1=fetching, 2=finishing last word.
  int              m_mode;
  int              m_pc;
  logic [IW-1:0]   m_ir;
  int              m_irpc;
  bit              m_vld;
  bit              m_wrap;

  function automatic bit m_can_fetch();
    return (m_mode == 1) && (!m_vld || ir_ready) && !jmp_en && !halt;
  endfunction

  task automatic model_step();
    bit fetch;
    bit taken;
    fetch = m_can_fetch();
    taken = m_vld && ir_ready;
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_ir = '0; m_irpc = 0; m_vld = 0; m_wrap = 0;
      return;
    end
    m_wrap = 0;
    if (jmp_en) begin
      m_pc = jmp_addr;
      m_vld = 0;
      if (m_mode == 2 || (m_mode == 1 && halt)) m_mode = 0;
      else if (m_mode == 0 && run && !halt) m_mode = 1;
    end else if (m_mode == 0) begin
      if (run && !halt) m_mode = 1;
    end else if (m_mode == 2) begin
      if (taken) begin m_vld = 0; m_mode = 0; end
    end else if (halt) begin
      if (m_vld && !ir_ready) m_mode = 2;
      else begin m_vld = 0; m_mode = 0; end
    end else if (fetch) begin
      m_ir   = rom_word(m_pc[PCW-1:0]);
      m_irpc = m_pc;
      m_vld  = 1;
      m_wrap = (m_pc == 255);
      m_pc   = (m_pc + 1) % 256;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("rom_en",   32'(rom_en),   32'(m_can_fetch()));
    chk("busy",     32'(busy),     32'(m_mode != 0));
    chk("ir_valid", 32'(ir_valid), 32'(m_vld));
    chk("wrap",     32'(wrap),     32'(m_wrap));
    chk("ir",       32'(ir),       32'(m_ir));
    chk("ir_pc",    32'(ir_pc),    32'(m_irpc));
  endtask

  // One clock: DUT and model advance on the edge, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_ir = '0; m_irpc = 0; m_vld = 0; m_wrap = 0;
    rst_n = 1'b0; run = 1'b0; halt = 1'b0; jmp_en = 1'b0; jmp_addr = '0; ir_ready = 1'b0;
    @(negedge clk);

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_ir_valid", 32'(ir_valid), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    end

    // Start: run pulse, first word valid two edges later.
    rst_n = 1'b1; ir_ready = 1'b1; run = 1'b1;
    cycle();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_vld0", 32'(ir_valid), 32'd0);
    run = 1'b0;
    cycle();
    chk("start_vld1", 32'(ir_valid), 32'd1);
    chk("start_pc0", 32'(ir_pc), 32'd0);
    cycle();
    chk("start_ir1", 32'(ir), 32'h0F0);
    for (int i = 2; i <= 5; i++) begin
      cycle();
      chk("stream_pc", 32'(ir_pc), 32'(i));
    end

    // Backpressure at ir_pc=5 for 4 cycles.
    ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_irpc", 32'(ir_pc), 32'd5);
      chk("bp_addr", 32'(rom_addr), 32'd6);
    end
    ir_ready = 1'b1;
    cycle();
    chk("bp_next", 32'(ir_pc), 32'd6);

    // Jump to 0 and stream up to ir_pc=3.
    jmp_en = 1'b1; jmp_addr = 8'h00;
    cycle();
    jmp_en = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("pre_jmp_pc3", 32'(ir_pc), 32'd3);

    // Jump to 0xA0 with word 3 stalled: flushed, one bubble.
    ir_ready = 1'b0; jmp_en = 1'b1; jmp_addr = 8'hA0;
    cycle();
    chk("jmp_bubble", 32'(ir_valid), 32'd0);
    chk("jmp_addr", 32'(rom_addr), 32'hA0);
    jmp_en = 1'b0; ir_ready = 1'b1;
    cycle();
    chk("jmp_tgt_pc", 32'(ir_pc), 32'hA0);
    chk("jmp_tgt_ir", 32'(ir), 32'h0A0);

    // Wrap through 0xFF.
    jmp_en = 1'b1; jmp_addr = 8'hFE;
    cycle();
    jmp_en = 1'b0;
    cycle(); chk("wrap_fe", 32'(ir_pc), 32'hFE); chk("wrap_fe_w", 32'(wrap), 32'd0);
    cycle(); chk("wrap_ff", 32'(ir_pc), 32'hFF); chk("wrap_ff_w", 32'(wrap), 32'd1);
    cycle(); chk("wrap_00", 32'(ir_pc), 32'h00); chk("wrap_00_w", 32'(wrap), 32'd0);
    cycle(); chk("wrap_01", 32'(ir_pc), 32'h01);

    // Halt with a stalled word: drain, run ignored, idle after transfer.
    ir_ready = 1'b0; halt = 1'b1;
    cycle();
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_en", 32'(rom_en), 32'd0);
    halt = 1'b0; run = 1'b1;
    cycle();
    chk("drain_vld", 32'(ir_valid), 32'd1);
    chk("drain_en2", 32'(rom_en), 32'd0);
    run = 1'b0; ir_ready = 1'b1;
    cycle();
    chk("drain_done", 32'(busy), 32'd0);
    chk("drain_vld0", 32'(ir_valid), 32'd0);
    cycle();
    chk("drain_idle", 32'(rom_en), 32'd0);

    // Reset mid-run.
    run = 1'b1; cycle(); run = 1'b0; cycle(); cycle();
    chk("mid_vld", 32'(ir_valid), 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_vld", 32'(ir_valid), 32'd0);
    chk("mid_rst_pc", 32'(rom_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_no_fetch", 32'(rom_en), 32'd0);
    end

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      run      = ($urandom_range(0, 3) == 0);
      halt     = ($urandom_range(0, 7) == 0);
      jmp_en   = ($urandom_range(0, 9) == 0);
      jmp_addr = ($urandom_range(0, 3) == 0) ? 8'hFE : PCW'($urandom);
      ir_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
